// File: rtl/mips_core_pkg.sv
// Shared integer-pipeline types and queue geometry.
// Defines the issue payload bundle and integer issue queue sizing constants.
package mips_core_pkg;

  localparam int INT_QUEUE_SIZE = 8;
  localparam int INT_QUEUE_IDX  = $clog2(INT_QUEUE_SIZE);

  typedef struct packed {
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] immediate;
    logic [5:0]  alu_ctl;
    logic        is_branch;
    logic        prediction;
    logic [31:0] recovery_target;
    logic [7:0]  active_list_id;
  } int_issue_payload_t;

  localparam int INT_PAYLOAD_W = $bits(int_issue_payload_t);

endpackage

// File: rtl/age_matrix.sv
// Occupancy + age matrix for the integer issue queue; yields the oldest eligible entry.
// Ports: clk, rst, flush, alloc_valid/alloc_idx, clear_oh, ready_mask -> occ, oldest_oh.
module age_matrix
  import mips_core_pkg::*;
#(
  parameter int N   = INT_QUEUE_SIZE,
  parameter int IDX = INT_QUEUE_IDX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [1:0]     alloc_valid,
  input  logic [2*IDX-1:0] alloc_idx,
  input  logic [N-1:0]   clear_oh,
  input  logic [N-1:0]   ready_mask,
  output logic [N-1:0]   occ,
  output logic [N-1:0]   oldest_oh
);

  // older_q[i][j] = 1 : entry i is older than entry j
  logic [N-1:0][N-1:0] older_q, older_d;
  logic [N-1:0]        occ_q, occ_d;
  logic [N-1:0]        elig;
  logic [IDX-1:0]      a;

  always_comb begin
    occ_d   = occ_q & ~clear_oh;
    older_d = older_q;
    a       = '0;
    for (int i = 0; i < N; i++) begin
      if (clear_oh[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < N; j++) older_d[j][i] = 1'b0;
      end
    end
    // slot 0 lands first so slot 1 sees it as already occupied
    for (int s = 0; s < 2; s++) begin
      if (alloc_valid[s]) begin
        a = alloc_idx[s*IDX +: IDX];
        older_d[a] = '0;
        for (int j = 0; j < N; j++) older_d[j][a] = occ_d[j];
        occ_d[a] = 1'b1;
      end
    end
    if (flush) begin
      occ_d   = '0;
      older_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      older_q <= '0;
    end else begin
      occ_q   <= occ_d;
      older_q <= older_d;
    end
  end

  assign elig = ready_mask & occ_q;

  always_comb begin
    oldest_oh = '0;
    for (int i = 0; i < N; i++) begin
      logic blk;
      blk = 1'b0;
      for (int j = 0; j < N; j++) blk = blk | (elig[j] & older_q[j][i]);
      oldest_oh[i] = elig[i] & ~blk;
    end
  end

  assign occ = occ_q;

  a_alloc0_free: assert property (@(posedge clk) disable iff (rst)
    alloc_valid[0] |-> !occ_q[alloc_idx[IDX-1:0]]);
  a_alloc1_free: assert property (@(posedge clk) disable iff (rst)
    alloc_valid[1] |-> (!occ_q[alloc_idx[2*IDX-1:IDX]] &&
      !(alloc_valid[0] && alloc_idx[IDX-1:0] == alloc_idx[2*IDX-1:IDX])));

endmodule

// File: rtl/int_issue_select.sv
// Integer issue select: oldest-ready pick, registered issue->regread slot, queue grant.
// Ports: clk/rst, alloc_*, ready_mask, entry_payload, flush, grant_*, out_* handshake,
// stat_grants/stat_blocked (live only with INT_ISSUE_SELECT_STATS_EN, else tied 0).
module int_issue_select
  import mips_core_pkg::*;
#(
  parameter int QUEUE_SIZE = INT_QUEUE_SIZE,
  parameter int QUEUE_IDX  = INT_QUEUE_IDX,
  parameter int PAYLOAD_W  = INT_PAYLOAD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                alloc_valid,
  input  logic [2*QUEUE_IDX-1:0]    alloc_idx,
  input  logic [QUEUE_SIZE-1:0]     ready_mask,
  input  logic [QUEUE_SIZE*PAYLOAD_W-1:0] entry_payload,
  input  logic                      flush,
  output logic                      grant_valid,
  output logic [QUEUE_IDX-1:0]      grant_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [QUEUE_IDX-1:0]      out_idx,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_blocked
);

  logic [QUEUE_SIZE-1:0] occ;
  logic [QUEUE_SIZE-1:0] oldest_oh;
  logic [QUEUE_SIZE-1:0] clear_oh;
  logic                  any_elig;
  logic                  can_load;

  age_matrix #(
    .N   (QUEUE_SIZE),
    .IDX (QUEUE_IDX)
  ) u_age (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .clear_oh    (clear_oh),
    .ready_mask  (ready_mask),
    .occ         (occ),
    .oldest_oh   (oldest_oh)
  );

  assign any_elig    = |oldest_oh;
  assign can_load    = !out_valid | out_ready;
  assign grant_valid = can_load & any_elig & !flush;
  assign clear_oh    = grant_valid ? oldest_oh : '0;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < QUEUE_SIZE; i++)
      if (oldest_oh[i]) grant_idx = grant_idx | QUEUE_IDX'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_idx     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (grant_valid) begin
      out_valid   <= 1'b1;
      out_payload <= entry_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W];
      out_idx     <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INT_ISSUE_SELECT_STATS_EN
  logic [31:0] grants_q, blocked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q  <= '0;
      blocked_q <= '0;
    end else begin
      if (grant_valid)
        grants_q <= grants_q + 32'd1;
      if (any_elig && !can_load && !flush)
        blocked_q <= blocked_q + 32'd1;
    end
  end

  assign stat_grants  = grants_q;
  assign stat_blocked = blocked_q;
`else
  assign stat_grants  = '0;
  assign stat_blocked = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^occ;

endmodule

// File: tb/tb_int_issue_select.sv
// Randomised + directed bench for int_issue_select against an age-ordered list model.
// Build with INT_ISSUE_SELECT_STATS_EN to exercise the stat counters.
module tb_int_issue_select;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_valid;
  logic [5:0]  alloc_idx;
  logic [7:0]  ready_mask;
  logic [767:0] entry_payload;
  logic        flush;
  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_payload;
  logic [2:0]  out_idx;
  logic [31:0] stat_grants;
  logic [31:0] stat_blocked;

  int_issue_select dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_idx     (alloc_idx),
    .ready_mask    (ready_mask),
    .entry_payload (entry_payload),
    .flush         (flush),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_payload   (out_payload),
    .out_idx       (out_idx),
    .stat_grants   (stat_grants),
    .stat_blocked  (stat_blocked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: entries in allocation order, oldest at the front
  int          age_q[$];
  logic        m_ov;
  logic [2:0]  m_oi;
  logic [95:0] m_op;
  logic [31:0] m_g, m_b;
  logic        cap_gv;
  logic [2:0]  cap_gi;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int v);
    foreach (age_q[k]) if (age_q[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk_stats();
`ifdef INT_ISSUE_SELECT_STATS_EN
    chk("stat_grants", stat_grants, m_g);
    chk("stat_blocked", stat_blocked, m_b);
`else
    chk("stat_grants_off", stat_grants, 0);
    chk("stat_blocked_off", stat_blocked, 0);
`endif
  endtask

  task automatic step(input logic [1:0] av, input int i0, input int i1,
                      input logic [7:0] rm, input logic fl,
                      input logic ordy);
    int win;
    bit found;
    bit can;
    bit eg;
    logic [95:0] pl;
    @(negedge clk);
    alloc_valid = av;
    alloc_idx   = {3'(i1), 3'(i0)};
    ready_mask  = rm;
    flush       = fl;
    out_ready   = ordy;
    for (int e = 0; e < 8; e++)
      entry_payload[e*96 +: 96] = {$urandom(), $urandom(), $urandom()};
    #1;
    can = !m_ov || ordy;
    found = 0;
    win = 0;
    foreach (age_q[k])
      if (!found && rm[age_q[k]]) begin
        found = 1;
        win = age_q[k];
      end
    eg = can && found && !fl;
    cap_gv = grant_valid;
    cap_gi = grant_idx;
    chk("grant_valid", grant_valid, eg);
    if (eg) chk("grant_idx", grant_idx, win);
    pl = entry_payload[win*96 +: 96];
    if (eg) m_g++;
    if (found && !can && !fl) m_b++;
    if (fl) begin
      age_q.delete();
      m_ov = 0;
    end else begin
      if (eg) begin
        for (int k = 0; k < age_q.size(); k++)
          if (age_q[k] == win) begin
            age_q.delete(k);
            break;
          end
        m_ov = 1;
        m_oi = 3'(win);
        m_op = pl;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (av[0]) age_q.push_back(i0);
      if (av[1]) age_q.push_back(i1);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_idx", out_idx, m_oi);
      chk("out_payload", out_payload, m_op);
    end
    chk_stats();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    alloc_valid = 2'b11;
    alloc_idx = 6'o21;
    ready_mask = 8'hFF;
    flush = 0;
    out_ready = 1;
    entry_payload = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    alloc_valid = 0;
    age_q.delete();
    m_ov = 0; m_oi = 0; m_op = 0; m_g = 0; m_b = 0;
    #1;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_payload", out_payload, 0);
    chk_stats();
  endtask

  initial begin
    int exp_o[3];
    logic [95:0] held;
    logic [31:0] g0, b0;
    int fr[$];
    int p0, p1;
    logic [1:0] av;

    do_reset();

    // age order 5, 2, 7
    step(2'b01, 5, 0, 8'h00, 0, 1);
    step(2'b01, 2, 0, 8'h00, 0, 1);
    step(2'b01, 7, 0, 8'h00, 0, 1);
    exp_o = '{5, 2, 7};
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 0, 0, 8'hA4, 0, 1);
      chk("age_grant", cap_gi, exp_o[k]);
      chk("age_out_idx", out_idx, exp_o[k]);
    end

    // same-cycle alloc: slot 0 older
    step(2'b00, 0, 0, 8'h00, 1, 1);
    step(2'b11, 3, 1, 8'h00, 0, 1);
    step(2'b00, 0, 0, 8'h0A, 0, 1);
    chk("same_first", cap_gi, 3);
    step(2'b00, 0, 0, 8'h0A, 0, 1);
    chk("same_second", cap_gi, 1);

    // backpressure
    step(2'b00, 0, 0, 8'h00, 1, 1);
    step(2'b11, 0, 4, 8'h00, 0, 1);
    step(2'b00, 0, 0, 8'h01, 0, 1);
    held = out_payload;
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 0, 0, 8'h10, 0, 0);
      chk("bp_no_grant", cap_gv, 0);
      chk("bp_hold", out_payload, held);
    end
    step(2'b00, 0, 0, 8'h10, 0, 1);
    chk("bp_release", cap_gi, 4);
    chk("bp_out_idx", out_idx, 4);

    // flush beats concurrent alloc
    step(2'b00, 0, 0, 8'h00, 1, 1);
    step(2'b11, 1, 2, 8'h00, 0, 1);
    step(2'b01, 3, 0, 8'h00, 0, 1);
    step(2'b01, 0, 0, 8'h02, 0, 1);
    step(2'b01, 6, 0, 8'hFF, 1, 0);
    chk("fl_out_valid", out_valid, 0);
    step(2'b00, 0, 0, 8'hFF, 0, 1);
    chk("fl_no_grant", cap_gv, 0);

    // 4 grants then 5 blocked cycles
    step(2'b00, 0, 0, 8'h00, 1, 1);
    step(2'b11, 0, 1, 8'h00, 0, 1);
    step(2'b11, 2, 3, 8'h00, 0, 1);
    step(2'b01, 4, 0, 8'h00, 0, 1);
    g0 = stat_grants;
    b0 = stat_blocked;
    repeat (4) step(2'b00, 0, 0, 8'hFF, 0, 1);
    repeat (5) step(2'b00, 0, 0, 8'hFF, 0, 0);
`ifdef INT_ISSUE_SELECT_STATS_EN
    chk("st_grants4", stat_grants - g0, 4);
    chk("st_blocked5", stat_blocked - b0, 5);
`else
    chk("st_grants_tied", stat_grants | g0, 0);
    chk("st_blocked_tied", stat_blocked | b0, 0);
`endif

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      fr.delete();
      for (int e = 0; e < 8; e++) if (!in_q(e)) fr.push_back(e);
      av = 2'($urandom_range(0, 3));
      p0 = 0;
      p1 = 0;
      if (fr.size() == 0) begin
        av = 0;
      end else begin
        int r;
        r = int'($urandom_range(0, fr.size() - 1));
        p0 = fr[r];
        fr.delete(r);
        if (fr.size() == 0) av[1] = 1'b0;
        else p1 = fr[$urandom_range(0, fr.size() - 1)];
      end
      step(av, p0, p1, 8'($urandom()),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
